pc_ir_unit: RTL and testbench

- Program counter and instruction register stage feeding the control unit: holds PC, drives the instruction-memory address, and captures the fetched word into IR.
- Acts on the control unit's PC-select (ps) and instruction-load (il) strobes.
- IR output drives the control unit's ins_in; IR bits [8:6],[2:0] supply the branch offset.
- Also keeps a saturating fetch counter and a sticky PC-wrap flag for debug/test.

---
 rtl/pc_ir_unit_pkg.sv | 18 +
 rtl/pc_ir_unit_if.sv | 28 ++
 rtl/pc_ir_unit_pc_next_logic.sv | 42 ++++
 rtl/pc_ir_unit.sv | 55 +++++
 tb/tb_pc_ir_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pc_ir_unit_pkg.sv
// Shared types and constants for the PC / IR fetch stage.
package pc_ir_unit_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BRA  = 2'b10,
    PS_JMP  = 2'b11
  } pc_sel_t;

  localparam int BR_OFF_W = 6;

  // Branch offset lives in two split fields of the instruction word.
  function automatic logic [BR_OFF_W-1:0] br_field(input logic [8:0] ir_low);
    return {ir_low[8:6], ir_low[2:0]};
  endfunction

endpackage

// File: rtl/pc_ir_unit_if.sv
// Control-unit side bus of the fetch stage: PC select, IR load, memory word and status.
interface pc_ir_unit_if
  import pc_ir_unit_pkg::*;
#(
  parameter int DATAW = 16,
  parameter int ICNTW = 16
);

  pc_sel_t            ps_in;
  logic               il_in;
  logic [DATAW-1:0]   mem_data_in;
  logic [DATAW-1:0]   ra_in;
  logic [DATAW-1:0]   pc_out;
  logic [DATAW-1:0]   ins_out;
  logic [ICNTW-1:0]   icnt_out;
  logic               pcwrap_out;

  modport master (
    output ps_in, il_in, mem_data_in, ra_in,
    input  pc_out, ins_out, icnt_out, pcwrap_out
  );

  modport slave (
    input  ps_in, il_in, mem_data_in, ra_in,
    output pc_out, ins_out, icnt_out, pcwrap_out
  );

endinterface

// File: rtl/pc_ir_unit_pc_next_logic.sv
// Next-PC selection and address-space wrap detection (purely combinational).
module pc_next_logic
  import pc_ir_unit_pkg::*;
#(
  parameter int DATAW = 16
) (
  input  logic [DATAW-1:0]    pc,
  input  logic [BR_OFF_W-1:0] off,
  input  logic [DATAW-1:0]    ra,
  input  pc_sel_t             ps,
  output logic [DATAW-1:0]    pc_next,
  output logic                wrap
);

  logic [DATAW:0] off_ext;
  logic [DATAW:0] inc_sum;
  logic [DATAW:0] br_sum;

  // Extra top bit catches carry on forward branches and borrow on backward ones.
  assign off_ext = {{(DATAW + 1 - BR_OFF_W){off[BR_OFF_W-1]}}, off};
  assign inc_sum = {1'b0, pc} + (DATAW + 1)'(1);
  assign br_sum  = {1'b0, pc} + off_ext;

  always_comb begin
    pc_next = pc;
    wrap    = 1'b0;
    case (ps)
      PS_HOLD: pc_next = pc;
      PS_INC: begin
        pc_next = inc_sum[DATAW-1:0];
        wrap    = inc_sum[DATAW];
      end
      PS_BRA: begin
        pc_next = br_sum[DATAW-1:0];
        wrap    = br_sum[DATAW];
      end
      PS_JMP: pc_next = ra;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter / instruction register stage with saturating fetch count and sticky wrap flag.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int               DATAW    = 16,
  parameter logic [DATAW-1:0] RESET_PC = '0,
  parameter int               ICNTW    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_ir_unit_if.slave  bus
);

  logic [DATAW-1:0]    pc;
  logic [DATAW-1:0]    ir;
  logic [DATAW-1:0]    pc_next;
  logic                wrap_next;
  logic [ICNTW-1:0]    icnt;
  logic                pcwrap;
  logic [BR_OFF_W-1:0] br_off;

  // Offset always comes from the IR already held, never the word being loaded.
  assign br_off = br_field(ir[8:0]);

  pc_next_logic #(.DATAW(DATAW)) u_pc_next (
    .pc      (pc),
    .off     (br_off),
    .ra      (bus.ra_in),
    .ps      (bus.ps_in),
    .pc_next (pc_next),
    .wrap    (wrap_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      ir     <= '0;
      icnt   <= '0;
      pcwrap <= 1'b0;
    end else begin
      pc <= pc_next;
      if (bus.il_in) begin
        ir <= bus.mem_data_in;
        if (icnt != '1) icnt <= icnt + ICNTW'(1);
      end
      if (wrap_next) pcwrap <= 1'b1;
    end
  end

  assign bus.pc_out     = pc;
  assign bus.ins_out    = ir;
  assign bus.icnt_out   = icnt;
  assign bus.pcwrap_out = pcwrap;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus randomized traffic against an integer model.
module tb_pc_ir_unit;
  import pc_ir_unit_pkg::*;

  localparam int DATAW    = 16;
  localparam int ICNTW    = 4;
  localparam int ICNT_MAX = (1 << ICNTW) - 1;

  logic clk;
  logic rst_n;

  pc_ir_unit_if #(.DATAW(DATAW), .ICNTW(ICNTW)) bus ();

  pc_ir_unit #(.DATAW(DATAW), .RESET_PC(16'h0000), .ICNTW(ICNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc, m_ir, m_icnt;
  bit m_wrap;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && $isunknown(bus.ps_in)) begin
      n_checks++;
      n_fail++;
      $display("FAIL ps_known: ps_in=%b while out of reset", bus.ps_in);
    end
  end

  task automatic model_edge(input logic r, input int ps, input logic il, input int mem, input int ra);
    int t, field, off;
    if (!r) begin
      m_pc = 0; m_ir = 0; m_icnt = 0; m_wrap = 0;
      return;
    end
    field = ((m_ir >> 6) & 7) * 8 + (m_ir & 7);
    off   = (field >= 32) ? field - 64 : field;
    case (ps)
      0: t = m_pc;
      1: t = m_pc + 1;
      2: t = m_pc + off;
      default: t = ra;
    endcase
    if ((ps == 1 || ps == 2) && (t < 0 || t > 65535)) m_wrap = 1;
    m_pc = t & 32'hFFFF;
    if (il) begin
      m_ir = mem;
      if (m_icnt < ICNT_MAX) m_icnt++;
    end
  endtask

  task automatic drive_edge(input logic r, input pc_sel_t ps, input logic il,
                            input logic [15:0] mem, input logic [15:0] ra);
    rst_n           = r;
    bus.ps_in       = ps;
    bus.il_in       = il;
    bus.mem_data_in = mem;
    bus.ra_in       = ra;
    @(posedge clk);
    model_edge(r, int'(ps), il, int'(mem), int'(ra));
    #1;
  endtask

  task automatic test_reset();
    drive_edge(1'b0, PS_INC, 1'b1, 16'hBEEF, 16'h1111);
    drive_edge(1'b0, PS_INC, 1'b1, 16'hCAFE, 16'h2222);
    n_checks++; if (bus.pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", bus.pc_out); end
    n_checks++; if (bus.ins_out !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", bus.ins_out); end
    n_checks++; if (bus.icnt_out !== 4'h0) begin n_fail++; $display("FAIL reset_icnt: got %h want 0", bus.icnt_out); end
    n_checks++; if (bus.pcwrap_out !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", bus.pcwrap_out); end
    for (int i = 0; i < 3; i++) drive_edge(1'b1, PS_INC, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'h0003) begin n_fail++; $display("FAIL reset_release_pc: got %h want 0003", bus.pc_out); end
  endtask

  task automatic test_fetch();
    drive_edge(1'b0, PS_HOLD, 1'b0, 16'h0000, 16'h0000);
    drive_edge(1'b1, PS_JMP, 1'b0, 16'h0000, 16'h0010);
    drive_edge(1'b1, PS_HOLD, 1'b1, 16'h1234, 16'h0000);
    n_checks++; if (bus.ins_out !== 16'h1234) begin n_fail++; $display("FAIL fetch_ir: got %h want 1234", bus.ins_out); end
    n_checks++; if (bus.pc_out !== 16'h0010) begin n_fail++; $display("FAIL fetch_pc_hold: got %h want 0010", bus.pc_out); end
    drive_edge(1'b1, PS_INC, 1'b0, 16'h9999, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'h0011) begin n_fail++; $display("FAIL fetch_pc_inc: got %h want 0011", bus.pc_out); end
    n_checks++; if (bus.icnt_out !== 4'h1) begin n_fail++; $display("FAIL fetch_icnt: got %h want 1", bus.icnt_out); end
    n_checks++; if (bus.ins_out !== 16'h1234) begin n_fail++; $display("FAIL fetch_ir_hold: got %h want 1234", bus.ins_out); end
  endtask

  task automatic test_branch();
    drive_edge(1'b0, PS_HOLD, 1'b0, 16'h0000, 16'h0000);
    // 16'h01C6 carries offset field 111_110 = -2
    drive_edge(1'b1, PS_JMP, 1'b1, 16'h01C6, 16'h0020);
    drive_edge(1'b1, PS_BRA, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'h001E) begin n_fail++; $display("FAIL branch_back_pc: got %h want 001e", bus.pc_out); end
    n_checks++; if (bus.pcwrap_out !== 1'b0) begin n_fail++; $display("FAIL branch_back_wrap: got %b want 0", bus.pcwrap_out); end
    drive_edge(1'b1, PS_JMP, 1'b0, 16'h0000, 16'h0001);
    drive_edge(1'b1, PS_BRA, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'hFFFF) begin n_fail++; $display("FAIL branch_under_pc: got %h want ffff", bus.pc_out); end
    n_checks++; if (bus.pcwrap_out !== 1'b1) begin n_fail++; $display("FAIL branch_under_wrap: got %b want 1", bus.pcwrap_out); end
  endtask

  task automatic test_jump_load();
    drive_edge(1'b0, PS_HOLD, 1'b0, 16'h0000, 16'h0000);
    drive_edge(1'b1, PS_JMP, 1'b0, 16'h0000, 16'h0040);
    drive_edge(1'b1, PS_JMP, 1'b1, 16'h5A5A, 16'hABCD);
    n_checks++; if (bus.pc_out !== 16'hABCD) begin n_fail++; $display("FAIL jump_pc: got %h want abcd", bus.pc_out); end
    n_checks++; if (bus.ins_out !== 16'h5A5A) begin n_fail++; $display("FAIL jump_ir: got %h want 5a5a", bus.ins_out); end
    // 5A5A offset field = 001_010 = +10; concurrent load of FFFF must not affect it
    drive_edge(1'b1, PS_BRA, 1'b1, 16'hFFFF, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'hABD7) begin n_fail++; $display("FAIL jump_then_branch_pc: got %h want abd7", bus.pc_out); end
    n_checks++; if (bus.ins_out !== 16'hFFFF) begin n_fail++; $display("FAIL jump_then_branch_ir: got %h want ffff", bus.ins_out); end
    n_checks++; if (bus.pcwrap_out !== 1'b0) begin n_fail++; $display("FAIL jump_wrap: got %b want 0", bus.pcwrap_out); end
  endtask

  task automatic test_inc_wrap();
    drive_edge(1'b0, PS_HOLD, 1'b0, 16'h0000, 16'h0000);
    drive_edge(1'b1, PS_JMP, 1'b0, 16'h0000, 16'hFFFF);
    n_checks++; if (bus.pcwrap_out !== 1'b0) begin n_fail++; $display("FAIL jump_no_wrap: got %b want 0", bus.pcwrap_out); end
    drive_edge(1'b1, PS_INC, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (bus.pc_out !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap_pc: got %h want 0000", bus.pc_out); end
    n_checks++; if (bus.pcwrap_out !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_flag: got %b want 1", bus.pcwrap_out); end
    for (int i = 1; i <= 10; i++) begin
      drive_edge(1'b1, PS_INC, 1'b0, 16'h0000, 16'h0000);
      n_checks++; if (bus.pcwrap_out !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky[%0d]: got %b want 1", i, bus.pcwrap_out); end
    end
    n_checks++; if (bus.pc_out !== 16'h000A) begin n_fail++; $display("FAIL inc_after_wrap_pc: got %h want 000a", bus.pc_out); end
    drive_edge(1'b0, PS_INC, 1'b0, 16'h0000, 16'h0000);
    n_checks++; if (bus.pcwrap_out !== 1'b0) begin n_fail++; $display("FAIL wrap_cleared: got %b want 0", bus.pcwrap_out); end
  endtask

  task automatic test_icnt_sat();
    drive_edge(1'b0, PS_HOLD, 1'b0, 16'h0000, 16'h0000);
    for (int i = 1; i <= 20; i++) begin
      drive_edge(1'b1, PS_HOLD, 1'b1, 16'(i), 16'h0000);
      n_checks++;
      if (bus.icnt_out !== 4'((i > ICNT_MAX) ? ICNT_MAX : i)) begin
        n_fail++; $display("FAIL icnt_burst[%0d]: got %0d want %0d", i, bus.icnt_out, (i > ICNT_MAX) ? ICNT_MAX : i);
      end
    end
    drive_edge(1'b0, PS_HOLD, 1'b1, 16'h7777, 16'h0000);
    n_checks++; if (bus.icnt_out !== 4'h0) begin n_fail++; $display("FAIL icnt_mid_reset: got %0d want 0", bus.icnt_out); end
    n_checks++; if (bus.ins_out !== 16'h0000) begin n_fail++; $display("FAIL ir_mid_reset: got %h want 0000", bus.ins_out); end
    for (int i = 1; i <= 3; i++) drive_edge(1'b1, PS_HOLD, 1'b1, 16'h0000, 16'h0000);
    n_checks++; if (bus.icnt_out !== 4'h3) begin n_fail++; $display("FAIL icnt_after_reset: got %0d want 3", bus.icnt_out); end
  endtask

  task automatic test_random();
    logic          r;
    pc_sel_t       ps;
    logic          il;
    logic [15:0]   mem, ra;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) != 0);
      ps  = pc_sel_t'($urandom_range(0, 3));
      il  = 1'($urandom_range(0, 1));
      mem = 16'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      drive_edge(r, ps, il, mem, ra);
      n_checks++; if (bus.pc_out !== 16'(m_pc)) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, bus.pc_out, 16'(m_pc)); end
      n_checks++; if (bus.ins_out !== 16'(m_ir)) begin n_fail++; $display("FAIL rand_ir[%0d]: got %h want %h", i, bus.ins_out, 16'(m_ir)); end
      n_checks++; if (bus.icnt_out !== 4'(m_icnt)) begin n_fail++; $display("FAIL rand_icnt[%0d]: got %0d want %0d", i, bus.icnt_out, m_icnt); end
      n_checks++; if (bus.pcwrap_out !== m_wrap) begin n_fail++; $display("FAIL rand_wrap[%0d]: got %b want %b", i, bus.pcwrap_out, m_wrap); end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.ps_in       = PS_HOLD;
    bus.il_in       = 1'b0;
    bus.mem_data_in = '0;
    bus.ra_in       = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_branch();
    test_jump_load();
    test_inc_wrap();
    test_icnt_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
